// File: rtl/cci_mpf_csrs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_csrs_pkg
// Purpose  : MPF statistics event indices and the event-counter read FSM type.
// Revision : 1.0  initial release
// ============================================================================
package cci_mpf_csrs_pkg;

  // Event vector bit positions. Shim event outputs are packed in this order.
  localparam int CCI_MPF_EVT_VTP_4KB_HIT            = 0;
  localparam int CCI_MPF_EVT_VTP_2MB_HIT            = 1;
  localparam int CCI_MPF_EVT_VTP_4KB_MISS           = 2;
  localparam int CCI_MPF_EVT_VTP_2MB_MISS           = 3;
  localparam int CCI_MPF_EVT_VTP_PT_WALK_BUSY       = 4;
  localparam int CCI_MPF_EVT_VTP_FAILED_TRANSLATION = 5;
  localparam int CCI_MPF_EVT_VC_MAP_RD_VL0          = 6;
  localparam int CCI_MPF_EVT_VC_MAP_RD_VH0          = 7;
  localparam int CCI_MPF_EVT_VC_MAP_RD_VH1          = 8;
  localparam int CCI_MPF_EVT_VC_MAP_MAP_CHANGED     = 9;
  localparam int CCI_MPF_EVT_WRO_RD_CONFLICT        = 10;
  localparam int CCI_MPF_EVT_WRO_WR_CONFLICT        = 11;
  localparam int CCI_MPF_EVT_PWRITE                 = 12;

  localparam int CCI_MPF_EVT_NUM = 13;

  typedef logic [3:0] t_cci_mpf_evt_idx;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_SEL  = 2'd1,
    RD_RSP  = 2'd2
  } t_cci_mpf_evt_rd_state;

endpackage
`default_nettype wire

// File: rtl/cci_mpf_csr_event_ctr_one.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_csr_event_ctr_one
// Purpose  : One live event counter plus its snapshot copy.
//            CCI_MPF_CSR_EVENT_CTR_SAT_EN selects saturating instead of
//            wrapping counters.
// Revision : 1.0  initial release
// ============================================================================
module cci_mpf_csr_event_ctr_one
  import cci_mpf_csrs_pkg::*;
#(
  parameter int CTR_WIDTH = 48
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_inc,
  input  logic                 i_snap,
  input  logic                 i_clr,
  output logic [CTR_WIDTH-1:0] o_live,
  output logic [CTR_WIDTH-1:0] o_snap
);

  logic [CTR_WIDTH-1:0] r_live;
  logic [CTR_WIDTH-1:0] r_snap;
  logic [CTR_WIDTH-1:0] w_next;

`ifdef CCI_MPF_CSR_EVENT_CTR_SAT_EN
  assign w_next = (&r_live) ? r_live : r_live + CTR_WIDTH'(1);
`else
  assign w_next = r_live + CTR_WIDTH'(1);
`endif

  // Clear wins over a pending increment; that increment is dropped.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_live <= '0;
    end else if (i_inc) begin
      r_live <= w_next;
    end
  end

  // Snapshot takes the pre-clear live value even when clear coincides.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
    end else if (i_snap) begin
      r_snap <= r_live;
    end else if (i_clr) begin
      r_snap <= '0;
    end
  end

  assign o_live = r_live;
  assign o_snap = r_snap;

endmodule
`default_nettype wire

// File: rtl/cci_mpf_csr_event_ctr.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_csr_event_ctr
// Purpose  : MPF statistics event-counter bank with indexed live/snapshot
//            read sequencer. Option macro: CCI_MPF_CSR_EVENT_CTR_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module cci_mpf_csr_event_ctr
  import cci_mpf_csrs_pkg::*;
#(
  parameter int NUM_EVENTS = CCI_MPF_EVT_NUM,
  parameter int CTR_WIDTH  = 48,
  localparam int IDX_W     = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic                  rd_snap,
  output logic                  rd_ready,
  output logic                  rsp_valid,
  output logic [63:0]           rsp_data,
  input  logic                  snap_req,
  input  logic                  clr_req
);

  localparam int TAB_N = 2 ** IDX_W;

  logic [NUM_EVENTS-1:0] r_ev_q;
  logic [CTR_WIDTH-1:0]  w_live [NUM_EVENTS];
  logic [CTR_WIDTH-1:0]  w_snap [NUM_EVENTS];
  logic [63:0]           w_rd_tab [TAB_N];
  logic [63:0]           w_sel;

  t_cci_mpf_evt_rd_state r_state;
  logic                  r_rd_ready;
  logic                  r_rsp_valid;
  logic [63:0]           r_rsp_data;
  logic [IDX_W-1:0]      r_rd_idx;
  logic                  r_rd_snap;

  // New events are always captured; a coincident clear only drops r_ev_q's old content.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ev_q <= '0;
    end else begin
      r_ev_q <= events;
    end
  end

  for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_ctr
    cci_mpf_csr_event_ctr_one #(
      .CTR_WIDTH (CTR_WIDTH)
    ) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (r_ev_q[gi]),
      .i_snap (snap_req),
      .i_clr  (clr_req),
      .o_live (w_live[gi]),
      .o_snap (w_snap[gi])
    );
  end

  // Read table padded to the full index space; unused slots read as zero.
  for (genvar gt = 0; gt < TAB_N; gt++) begin : g_tab
    if (gt < NUM_EVENTS) begin : g_used
      assign w_rd_tab[gt] = r_rd_snap ? 64'(w_snap[gt]) : 64'(w_live[gt]);
    end else begin : g_pad
      assign w_rd_tab[gt] = 64'd0;
    end
  end

  assign w_sel = w_rd_tab[r_rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RD_IDLE;
      r_rd_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 64'd0;
      r_rd_idx    <= '0;
      r_rd_snap   <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (rd_req && r_rd_ready) begin
            r_rd_idx   <= rd_idx;
            r_rd_snap  <= rd_snap;
            r_rd_ready <= 1'b0;
            r_state    <= RD_SEL;
          end else begin
            r_rd_ready <= 1'b1;
          end
        end
        RD_SEL: begin
          r_rsp_data  <= w_sel;
          r_rsp_valid <= 1'b1;
          r_rd_ready  <= 1'b0;
          r_state     <= RD_RSP;
        end
        RD_RSP: begin
          r_rsp_valid <= 1'b0;
          r_rd_ready  <= 1'b1;
          r_state     <= RD_IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_rd_ready  <= 1'b0;
          r_state     <= RD_IDLE;
        end
      endcase
    end
  end

  assign rd_ready  = r_rd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_csr_event_ctr.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_csr_event_ctr
// Purpose  : Directed self-checking bench for cci_mpf_csr_event_ctr (4-bit counters).
// Revision : 1.0  initial release
// ============================================================================
module tb_cci_mpf_csr_event_ctr;

  localparam int NUM_EVENTS = 13;
  localparam int CTR_WIDTH  = 4;
  localparam int IDX_W      = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_EVENTS-1:0] events;
  logic                  rd_req;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_snap;
  logic                  rd_ready;
  logic                  rsp_valid;
  logic [63:0]           rsp_data;
  logic                  snap_req;
  logic                  clr_req;

  int n_tests = 0;
  int n_fail  = 0;

  cci_mpf_csr_event_ctr #(
    .NUM_EVENTS (NUM_EVENTS),
    .CTR_WIDTH  (CTR_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .events    (events),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_snap   (rd_snap),
    .rd_ready  (rd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .snap_req  (snap_req),
    .clr_req   (clr_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      events      = '0;
      events[idx] = 1'b1;
      tick();
    end
    events = '0;
  endtask

  // Full read with timing checks: accept, SEL, RSP, back to IDLE.
  task automatic do_read(input string tag, input int idx, input logic snap,
                         input logic [63:0] exp);
    int wait_cnt;
    wait_cnt = 0;
    while (rd_ready !== 1'b1 && wait_cnt < 10) begin
      tick();
      wait_cnt++;
    end
    if (rd_ready !== 1'b1) chk({tag, "_rdy_timeout"}, 64'(rd_ready), 64'd1);
    rd_req  = 1'b1;
    rd_idx  = IDX_W'(idx);
    rd_snap = snap;
    tick();
    rd_req = 1'b0;
    chk({tag, "_sel_rdy"}, 64'(rd_ready), 64'd0);
    chk({tag, "_sel_vld"}, 64'(rsp_valid), 64'd0);
    tick();
    chk({tag, "_rsp_rdy"}, 64'(rd_ready), 64'd0);
    chk({tag, "_rsp_vld"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_data"}, rsp_data, exp);
    tick();
    chk({tag, "_end_vld"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_end_rdy"}, 64'(rd_ready), 64'd1);
  endtask

  logic [63:0] ovf_exp;
  int          n_acc;
  int          n_rsp;

  initial begin
`ifdef CCI_MPF_CSR_EVENT_CTR_SAT_EN
    ovf_exp = 64'd15;
`else
    ovf_exp = 64'd1;
`endif
    reset = 1'b1; events = '0; rd_req = 1'b0; rd_idx = '0; rd_snap = 1'b0;
    snap_req = 1'b0; clr_req = 1'b0;
    idle(3);
    chk("rst_rdy", 64'(rd_ready), 64'd0);
    chk("rst_vld", 64'(rsp_valid), 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_rdy", 64'(rd_ready), 64'd1);

    // Basic count
    pulse(3, 5);
    idle(2);
    do_read("basic3", 3, 1'b0, 64'd5);

    // Snapshot coherence
    pulse(0, 10);
    idle(2);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    pulse(0, 4);
    idle(2);
    do_read("snap0", 0, 1'b1, 64'd10);
    do_read("live0", 0, 1'b0, 64'd14);

    // Event one cycle before clear is dropped
    events[5] = 1'b1; tick();
    events = '0; clr_req = 1'b1; tick(); clr_req = 1'b0;
    idle(2);
    do_read("clr_drop5", 5, 1'b0, 64'd0);
    do_read("clr_live0", 0, 1'b0, 64'd0);
    do_read("clr_snap0", 0, 1'b1, 64'd0);

    // Event in the clear cycle is kept
    events[6] = 1'b1; clr_req = 1'b1; tick();
    events = '0; clr_req = 1'b0;
    idle(2);
    do_read("clr_keep6", 6, 1'b0, 64'd1);

    // Snap together with clear keeps pre-clear value in snapshot
    pulse(7, 3);
    idle(2);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    pulse(7, 2);
    idle(2);
    snap_req = 1'b1; clr_req = 1'b1; tick();
    snap_req = 1'b0; clr_req = 1'b0;
    do_read("snapclr_snap7", 7, 1'b1, 64'd5);
    do_read("snapclr_live7", 7, 1'b0, 64'd0);

    // Overflow of a 4-bit counter
    pulse(2, 17);
    idle(2);
    do_read("ovf2", 2, 1'b0, ovf_exp);

    // Out-of-range index
    do_read("oor13", 13, 1'b0, 64'd0);
    do_read("oor15s", 15, 1'b1, 64'd0);

    // Back-to-back: rd_req held high for 12 cycles
    n_acc = 0; n_rsp = 0;
    rd_req = 1'b1; rd_idx = 4'd2; rd_snap = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (rd_ready === 1'b1) begin
        n_acc++;
        if (c % 3 != 0) chk("b2b_acc_cycle", 64'(c), 64'(3 * (c / 3)));
      end
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        chk("b2b_data", rsp_data, ovf_exp);
      end
      tick();
    end
    rd_req = 1'b0;
    chk("b2b_accepts", 64'(n_acc), 64'd4);
    chk("b2b_rsps", 64'(n_rsp), 64'd4);
    idle(1);

    // Reset asserted during SEL
    pulse(4, 2);
    idle(2);
    rd_req = 1'b1; rd_idx = 4'd4; rd_snap = 1'b0;
    tick();
    rd_req = 1'b0; reset = 1'b1;
    tick();
    chk("midrst_vld", 64'(rsp_valid), 64'd0);
    chk("midrst_rdy", 64'(rd_ready), 64'd0);
    reset = 1'b0;
    tick();
    chk("midrst_post_vld", 64'(rsp_valid), 64'd0);
    chk("midrst_post_rdy", 64'(rd_ready), 64'd1);
    do_read("midrst_live4", 4, 1'b0, 64'd0);
    do_read("midrst_live2", 2, 1'b0, 64'd0);
    do_read("midrst_snap7", 7, 1'b1, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
